// File: rtl/set_bit_walker_if.sv
// Word-in / beat-out handshake bundle for set_bit_walker.
// Both sides use valid/ready: a transfer happens on a cycle where valid and ready are both high;
// valid, once raised, holds along with its payload until that transfer.
interface set_bit_walker_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3
);
  logic [WORD_WIDTH-1:0]  word_in;
  logic                   word_in_valid;
  logic                   word_in_ready;
  logic [WORD_WIDTH-1:0]  onehot_out;
  logic [INDEX_WIDTH-1:0] index_out;
  logic                   last_out;
  logic                   none_out;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output word_in, word_in_valid, out_ready,
    input  word_in_ready, onehot_out, index_out, last_out, none_out, out_valid
  );

  modport slave (
    input  word_in, word_in_valid, out_ready,
    output word_in_ready, onehot_out, index_out, last_out, none_out, out_valid
  );
endinterface

// File: rtl/set_bit_walker.sv
// Walks the set bits of an accepted word, lowest first, one (one-hot, index, last) beat per cycle.
// A zero word yields a single beat flagged none_out.
module set_bit_walker #(
  parameter int WORD_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  set_bit_walker_if.slave    bus,
  output logic               dbg_state
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [WORD_WIDTH-1:0] ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state, state_next;
  logic [WORD_WIDTH-1:0]  remaining;
  logic [WORD_WIDTH-1:0]  lowest;
  logic [WORD_WIDTH-1:0]  cleared;
  logic [INDEX_WIDTH-1:0] index;
  logic                   last;
  logic                   emit;
  logic                   beat_done;
  logic                   accept;

  // Modulo 2^WORD_WIDTH arithmetic: a set top bit isolates cleanly with no carry out.
  assign lowest    = remaining & (~remaining + ONE);
  assign cleared   = remaining & (remaining - ONE);
  assign last      = (cleared == '0);
  assign emit      = (state == EMIT);
  assign beat_done = emit && bus.out_ready;
  assign accept    = bus.word_in_valid && bus.word_in_ready;

  always_comb begin
    index = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (lowest[i]) index = i[INDEX_WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.word_in_valid) state_next = EMIT;
      EMIT: if (bus.out_ready && last) state_next = bus.word_in_valid ? EMIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; ready opens in the final beat's handshake cycle so words chain without a bubble
  always_comb begin
    bus.out_valid     = 1'b0;
    bus.word_in_ready = 1'b0;
    case (state)
      IDLE: bus.word_in_ready = 1'b1;
      EMIT: begin
        bus.out_valid     = 1'b1;
        bus.word_in_ready = last && bus.out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       remaining <= '0;
    else if (accept)    remaining <= bus.word_in;
    else if (beat_done) remaining <= cleared;
  end

  assign bus.onehot_out = emit ? lowest : '0;
  assign bus.index_out  = emit ? index  : '0;
  assign bus.last_out   = emit && last;
  assign bus.none_out   = emit && (remaining == '0);
  assign dbg_state      = emit;

endmodule

// File: tb/tb_set_bit_walker.sv
// Directed bench for set_bit_walker: inputs driven and outputs sampled on the falling edge.
module tb_set_bit_walker;

  localparam int W  = 8;
  localparam int IW = 3;

  logic clock;
  logic reset_n;
  logic dbg_state;
  int   checks;
  int   failures;

  set_bit_walker_if #(.WORD_WIDTH(W), .INDEX_WIDTH(IW)) bus ();

  set_bit_walker #(.WORD_WIDTH(W), .INDEX_WIDTH(IW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers
  task automatic idle_inputs();
    bus.word_in       = '0;
    bus.word_in_valid = 1'b0;
    bus.out_ready     = 1'b1;
  endtask

  // Presents w for one rising edge from IDLE; returns at the next falling edge with valid dropped.
  task automatic send_word(input logic [W-1:0] w);
    @(negedge clock);
    bus.word_in       = w;
    bus.word_in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.word_in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out, bus.none_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b oh=%b idx=%0d last=%b none=%b, want all 0",
               bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out, bus.none_out);
    end
    checks++;
    if (bus.word_in_ready !== 1'b1 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_state: got ready=%b state=%b, want 1/0", bus.word_in_ready, dbg_state);
    end
  endtask

  task automatic test_walk();
    logic [W-1:0]  exp_oh [3] = '{8'b00001000, 8'b00100000, 8'b10000000};
    logic [IW-1:0] exp_idx[3] = '{3'd3, 3'd5, 3'd7};
    send_word(8'b10101000);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.onehot_out !== exp_oh[k] || bus.index_out !== exp_idx[k] ||
          bus.last_out !== (k == 2) || bus.none_out !== 1'b0) begin
        failures++;
        $display("FAIL walk_beat%0d: got v=%b oh=%b idx=%0d last=%b none=%b, want 1 %b %0d %b 0",
                 k, bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out, bus.none_out,
                 exp_oh[k], exp_idx[k], (k == 2));
      end
      checks++;
      if (bus.word_in_ready !== (k == 2)) begin
        failures++;
        $display("FAIL walk_ready%0d: got %b want %b", k, bus.word_in_ready, (k == 2));
      end
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b0 || dbg_state !== 1'b0 || bus.word_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL walk_idle: got v=%b state=%b ready=%b, want 0 0 1", bus.out_valid, dbg_state, bus.word_in_ready);
    end
  endtask

  task automatic test_zero();
    send_word(8'h00);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.onehot_out !== 8'h00 || bus.index_out !== 3'd0 ||
        bus.last_out !== 1'b1 || bus.none_out !== 1'b1 || bus.word_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_beat: got v=%b oh=%b idx=%0d last=%b none=%b ready=%b, want 1 0 0 1 1 1",
               bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out, bus.none_out, bus.word_in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL zero_single: got v=%b state=%b after one beat, want 0 0", bus.out_valid, dbg_state);
    end
  endtask

  task automatic test_all_ones();
    logic [W-1:0] oh;
    send_word(8'hFF);
    for (int k = 0; k < 8; k++) begin
      oh = 8'h01 << k;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.onehot_out !== oh || bus.index_out !== k[IW-1:0] ||
          bus.last_out !== (k == 7) || bus.none_out !== 1'b0) begin
        failures++;
        $display("FAIL ones_beat%0d: got v=%b oh=%b idx=%0d last=%b none=%b, want 1 %b %0d %b 0",
                 k, bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out, bus.none_out, oh, k, (k == 7));
      end
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ones_end: got v=%b want 0", bus.out_valid);
    end
    send_word(8'h80);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.onehot_out !== 8'h80 || bus.index_out !== 3'd7 ||
        bus.last_out !== 1'b1 || bus.none_out !== 1'b0) begin
      failures++;
      $display("FAIL top_bit: got v=%b oh=%b idx=%0d last=%b none=%b, want 1 10000000 7 1 0",
               bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out, bus.none_out);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL top_bit_end: got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    bus.out_ready = 1'b0;
    send_word(8'b00010010);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.onehot_out !== 8'b00000010 || bus.index_out !== 3'd1 ||
          bus.last_out !== 1'b0 || bus.word_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got v=%b oh=%b idx=%0d last=%b ready=%b, want 1 00000010 1 0 0",
                 c, bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out, bus.word_in_ready);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.index_out !== 3'd1 || bus.out_valid !== 1'b1 || bus.word_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: got idx=%0d v=%b ready=%b, want 1 1 0", bus.index_out, bus.out_valid, bus.word_in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.onehot_out !== 8'b00010000 || bus.index_out !== 3'd4 || bus.last_out !== 1'b1) begin
      failures++;
      $display("FAIL stall_second: got v=%b oh=%b idx=%0d last=%b, want 1 00010000 4 1",
               bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_end: got v=%b want 0 (duplicate beat)", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    bus.word_in       = 8'b00000110;
    bus.word_in_valid = 1'b1;
    step();
    bus.word_in = 8'b01000000;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.index_out !== 3'd1 || bus.last_out !== 1'b0 || bus.word_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_beat0: got v=%b idx=%0d last=%b ready=%b, want 1 1 0 0",
               bus.out_valid, bus.index_out, bus.last_out, bus.word_in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.index_out !== 3'd2 || bus.last_out !== 1'b1 || bus.word_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_beat1: got v=%b idx=%0d last=%b ready=%b, want 1 2 1 1",
               bus.out_valid, bus.index_out, bus.last_out, bus.word_in_ready);
    end
    step();
    bus.word_in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.onehot_out !== 8'b01000000 || bus.index_out !== 3'd6 || bus.last_out !== 1'b1) begin
      failures++;
      $display("FAIL b2b_beat2: got v=%b oh=%b idx=%0d last=%b, want 1 01000000 6 1",
               bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: got v=%b state=%b want 0 0", bus.out_valid, dbg_state);
    end
  endtask

  task automatic test_reset_mid_walk();
    send_word(8'b11000001);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.index_out !== 3'd0) begin
      failures++;
      $display("FAIL mid_first: got v=%b idx=%0d want 1 0", bus.out_valid, bus.index_out);
    end
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out, bus.none_out} !== '0 ||
        bus.word_in_ready !== 1'b1 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got v=%b oh=%b idx=%0d last=%b none=%b ready=%b state=%b, want 0s ready 1",
               bus.out_valid, bus.onehot_out, bus.index_out, bus.last_out, bus.none_out, bus.word_in_ready, dbg_state);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.word_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_after: got v=%b ready=%b want 0 1", bus.out_valid, bus.word_in_ready);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_walk();
    test_zero();
    test_all_ones();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_walk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/set_bit_walker.md
Name: set_bit_walker

Overview:
- Accepts one word per handshake and emits one output beat per set bit, lowest bit first, until the word is exhausted.
- Each beat carries the isolated rightmost 1 (one-hot), its binary index, and a last flag.
- Sits downstream of the rightmost-bit mask stages (turn-on/turn-off/isolate trailing bits). It turns their masks into a sequence of work items, e.g. grant lists or sparse-bit scanning.

Parameters:
- WORD_WIDTH, 8, width of input word and one-hot output; must be >= 2.
- INDEX_WIDTH, 3, width of binary index output; must equal clog2(WORD_WIDTH).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronous to clock.
- word_in  input  WORD_WIDTH  word to walk; sampled when word_in_valid and word_in_ready are both high.
- word_in_valid  input  1  upstream has a word.
- word_in_ready  output  1  block can accept a word this cycle.
- onehot_out  output  WORD_WIDTH  current isolated lowest set bit (remaining & -remaining).
- index_out  output  INDEX_WIDTH  bit position of onehot_out.
- last_out  output  1  this beat is the final beat for the current word.
- none_out  output  1  the current word was all zeros (single empty beat).
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.

Behaviour:
- Reset values: out_valid=0, onehot_out=0, index_out=0, last_out=0, none_out=0, internal remaining=0, state=IDLE. word_in_ready=1 after reset.
- States are IDLE and EMIT.
  - IDLE: word_in_ready=1, out_valid=0.
  - EMIT: out_valid=1.
- Accept occurs on word_in_valid & word_in_ready.
  - On accept, register remaining=word_in and enter EMIT.
  - The first beat is valid the next cycle (latency 1). There is no combinational path from word_in to outputs.
- In EMIT, outputs are computed from the registered remaining word:
  - onehot_out = remaining & (~remaining + 1)
  - index_out = priority encode of onehot_out
  - last_out = ((remaining & (remaining - 1)) == 0)
  - none_out = (remaining == 0)
- On out_valid & out_ready with last_out=0:
  - remaining <= remaining & (remaining - 1).
  - Stay in EMIT.
- On out_valid & out_ready with last_out=1:
  - Beat completes.
  - word_in_ready is asserted in that same cycle: word_in_ready = IDLE | (EMIT & last_out & out_ready).
  - If a new word is accepted in that cycle, load it and stay in EMIT with no bubble. Otherwise go to IDLE.
- Zero word: exactly one beat with onehot_out=0, index_out=0, last_out=1, none_out=1.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold stable and remaining is unchanged. out_valid never drops without a handshake.
- word_in is ignored whenever word_in_ready=0. Upstream must hold its word. The block does not buffer.
- Top bit set (bit WORD_WIDTH-1): index_out=WORD_WIDTH-1, with no overflow in the negate/decrement arithmetic. All arithmetic is modulo 2^WORD_WIDTH.
- Reset mid-walk: the remaining bits are discarded and the block returns to IDLE with reset values. No partial beat appears after reset deassertion.
- Beats per word = popcount(word), or 1 if the word is zero. Throughput is one beat per cycle with out_ready held high.

Test Plan:
- Reset, then accept 8'b10101000 with out_ready=1 → beats on consecutive cycles:
  - onehot 00001000 / index 3 / last 0
  - 00100000 / 5 / 0
  - 10000000 / 7 / 1
  - then IDLE.
- Accept 8'h00 → single beat: onehot 0, index 0, last 1, none 1. word_in_ready high in that beat's handshake cycle.
- Accept 8'hFF with out_ready=1 → 8 beats, indices 0..7, last only on index 7. Accept 8'h80 → one beat, index 7, last 1.
- 8'b00010010 with out_ready low for 3 cycles on the first beat → index 1 held stable for all 3 cycles. Then index 1 and index 4 complete, with no lost or duplicated beat.
- Back-to-back: 8'b00000110 then 8'b01000000 with word_in_valid held → beats at indices 1, 2, 6 on 3 consecutive cycles. The second word is accepted in the cycle of index 2.
- Assert reset_n low after the first beat of 8'b11000001 → outputs go to reset values immediately. After deassertion, out_valid=0 and word_in_ready=1.
